// File: rtl/nano_mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single memory port, one access in flight.
// Optional memory-wait timeout enabled by defining NANO_ARB_TIMEOUT_EN.
module nano_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_ack_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_d_q, sel_d_d;
  logic              grant_d, grant_if;

`ifdef NANO_ARB_TIMEOUT_EN
  localparam int unsigned WT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(TIMEOUT_CYCLES - 1);
  logic [WT_W-1:0] wait_q, wait_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Data wins ties unless the fetch has already been passed over STARVE_MAX times.
  assign grant_d  = d_req_i && !(if_req_i && (starve_q == STARVE_LIM));
  assign grant_if = if_req_i && !grant_d;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    sel_d_d  = sel_d_q;
`ifdef NANO_ARB_TIMEOUT_EN
    wait_d   = wait_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          sel_d_d  = 1'b1;
          addr_d   = d_addr_i;
          we_d     = d_we_i;
          be_d     = d_be_i;
          wdata_d  = d_wdata_i;
          starve_d = !if_req_i ? '0 :
                     (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end else if (grant_if) begin
          state_d  = BUSY_IF;
          sel_d_d  = 1'b0;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          be_d     = '1;
          wdata_d  = '0;
          starve_d = '0;
        end
`ifdef NANO_ARB_TIMEOUT_EN
        wait_d = '0;
        err_d  = 1'b0;
`endif
      end
      BUSY_IF, BUSY_D: begin
        if (m_ack_i) begin
          state_d = RESP;
          rdata_d = (sel_d_q && we_q) ? '0 : m_rdata_i;
`ifdef NANO_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_d_q  <= 1'b0;
`ifdef NANO_ARB_TIMEOUT_EN
      wait_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sel_d_q  <= sel_d_d;
`ifdef NANO_ARB_TIMEOUT_EN
      wait_q   <= wait_d;
      err_q    <= err_d;
`endif
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign m_req_o    = (state_q == BUSY_IF) || (state_q == BUSY_D);
  assign m_we_o     = we_q;
  assign m_be_o     = be_q;
  assign m_addr_o   = addr_q;
  assign m_wdata_o  = wdata_q;
  assign if_ack_o   = (state_q == RESP) && !sel_d_q;
  assign d_ack_o    = (state_q == RESP) && sel_d_q;
  assign if_rdata_o = if_ack_o ? rdata_q : '0;
  assign d_rdata_o  = d_ack_o ? rdata_q : '0;
`ifdef NANO_ARB_TIMEOUT_EN
  assign err_o      = (state_q == RESP) && err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Randomized + directed bench for nano_mem_arbiter (default build, timeout feature off).
module tb_nano_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [3:0]    d_be_i = '0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_ack_o;
  logic [DW-1:0] d_rdata_o;
  logic          m_req_o, m_we_o;
  logic [3:0]    m_be_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic          m_ack_i = 1'b0;
  logic [DW-1:0] m_rdata_i = '0;
  logic          busy_o, err_o;

  int n_chk = 0;
  int n_pass = 0;

  // Memory responder controls
  int          mem_delay = 0;
  int          mem_wait = 0;
  bit          mem_fix_en = 1'b0;
  logic [31:0] mem_fix = '0;
  bit          spur_en = 1'b0;

  always #5 clk = ~clk;

  nano_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: transaction phase 0=free, 1=memory access open, 2=answer cycle.
  int          e_phase = 0;
  bit          e_is_d = 1'b0;
  int          e_streak = 0;  // data grants in a row while a fetch was waiting
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
  logic        e_we = 1'b0;
  logic [3:0]  e_be = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_phase <= 0; e_is_d <= 1'b0; e_streak <= 0;
      e_addr <= '0; e_wdata <= '0; e_rdata <= '0; e_we <= 1'b0; e_be <= '0;
    end else if (e_phase == 0) begin
      if (d_req_i && !(if_req_i && e_streak >= STARVE)) begin
        e_phase <= 1; e_is_d <= 1'b1; e_addr <= d_addr_i; e_we <= d_we_i;
        e_be <= d_be_i; e_wdata <= d_wdata_i;
        e_streak <= if_req_i ? e_streak + 1 : 0;
      end else if (if_req_i) begin
        e_phase <= 1; e_is_d <= 1'b0; e_addr <= if_addr_i; e_we <= 1'b0;
        e_be <= 4'hF; e_streak <= 0;
      end
    end else if (e_phase == 1) begin
      if (m_ack_i) begin
        e_phase <= 2;
        e_rdata <= (e_is_d && e_we) ? 32'h0 : m_rdata_i;
      end
    end else begin
      e_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ctl{busy,mreq,ifack,dack,err}", {busy_o, m_req_o, if_ack_o, d_ack_o, err_o},
            {e_phase != 0, e_phase == 1, e_phase == 2 && !e_is_d, e_phase == 2 && e_is_d,
             1'b0});
      check("if_rdata", if_rdata_o, (e_phase == 2 && !e_is_d) ? e_rdata : 32'h0);
      check("d_rdata", d_rdata_o, (e_phase == 2 && e_is_d) ? e_rdata : 32'h0);
      if (e_phase == 1) begin
        check("m_fields", {m_addr_o, m_we_o, m_be_o}, {e_addr, e_we, e_be});
        if (e_we) check("m_wdata", m_wdata_o, e_wdata);
      end
    end
  end

  always @(negedge clk) begin
    m_ack_i = 1'b0;
    if (rst) mem_wait = 0;
    else if (m_req_o) begin
      if (mem_wait >= mem_delay) begin
        m_ack_i = 1'b1;
        m_rdata_i = mem_fix_en ? mem_fix : $urandom;
        mem_wait = 0;
      end else mem_wait++;
    end else begin
      mem_wait = 0;
      if (spur_en && $urandom_range(7) == 0) begin
        m_ack_i = 1'b1;
        m_rdata_i = $urandom;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin : main
    logic [31:0] stab_addr;
    bit grants[$];
    bit prev_req, seen_f, if_rel, d_rel, done;
    int nd, busy_cnt;

    // Reset state
    tick();
    check("rst_outputs", {busy_o, m_req_o, if_ack_o, d_ack_o, err_o, m_we_o, m_be_o}, 64'h0);
    check("rst_mem_bus", {m_addr_o, m_wdata_o}, 64'h0);
    check("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    rst = 1'b0;

    // Fetch-only
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h10; mem_fix_en = 1'b1; mem_fix = 32'hDEADBEEF;
    mem_delay = 0;
    tick();
    check("fetch_mreq", {m_req_o, m_we_o, m_be_o, m_addr_o}, {1'b1, 1'b0, 4'hF, 32'h10});
    tick();
    check("fetch_ack", {if_ack_o, d_ack_o, if_rdata_o}, {1'b1, 1'b0, 32'hDEADBEEF});
    tick();
    if_req_i = 1'b0;
    check("fetch_ack_pulse", if_ack_o, 1'b0);

    // Collision: data first, fetch right after
    if_req_i = 1'b1; if_addr_i = 32'h20;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h55; d_be_i = 4'hF;
    mem_fix = 32'h77;
    tick();
    check("coll_d_first", {m_req_o, m_we_o, m_addr_o, m_wdata_o},
          {1'b1, 1'b1, 32'h200, 32'h55});
    tick();
    check("coll_d_ack", {d_ack_o, if_ack_o, d_rdata_o}, {1'b1, 1'b0, 32'h0});
    tick();
    d_req_i = 1'b0;
    tick();
    check("coll_if_grant", {m_req_o, m_we_o, m_addr_o}, {1'b1, 1'b0, 32'h20});
    tick();
    check("coll_if_ack", {if_ack_o, if_rdata_o}, {1'b1, 32'h77});
    tick();
    if_req_i = 1'b0;

    // Starvation: fetch held while data requests back-to-back
    mem_fix_en = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    prev_req = 1'b0; seen_f = 1'b0; if_rel = 1'b0; d_rel = 1'b0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (if_rel) begin if_req_i = 1'b0; if_rel = 1'b0; end
      if (d_rel) begin d_req_i = 1'b0; d_rel = 1'b0; end
      if (m_req_o && !prev_req) begin
        grants.push_back(m_addr_o == 32'h100);
        if (m_addr_o == 32'h100) seen_f = 1'b1;
      end
      prev_req = m_req_o;
      if (if_ack_o) if_rel = 1'b1;
      if (d_ack_o && seen_f) d_rel = 1'b1;
      done = !if_req_i && !d_req_i && !busy_o;
    end
    check("starve_done", done, 1'b1);
    nd = 0;
    foreach (grants[i]) begin
      if (grants[i]) break;
      nd++;
    end
    check("starve_d_grants", nd, STARVE);
    check("starve_f_seen", seen_f, 1'b1);

    // Stability under a 7-cycle memory delay
    mem_delay = 6;
    stab_addr = 32'h400;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = stab_addr; d_wdata_i = 32'hA5A5_0001;
    d_be_i = 4'h3;
    busy_cnt = 0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (m_req_o) begin
        busy_cnt++;
        check("stable_fields", {m_addr_o, m_we_o, m_be_o, m_wdata_o[15:0]},
              {stab_addr, 1'b1, 4'h3, 16'h0001});
        d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom); d_we_i = 1'($urandom);
      end
      done = d_ack_o;
    end
    check("stable_ack", done, 1'b1);
    check("stable_cycles", busy_cnt, 7);
    tick();
    d_req_i = 1'b0;

    // Reset in the middle of a data access
    mem_delay = 100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
    tick();
    tick();
    check("pre_rst_busy", {m_req_o, m_addr_o}, {1'b1, 32'h500});
    #2 rst = 1'b1;
    d_req_i = 1'b0;
    #1;
    check("midrst_ctl", {busy_o, m_req_o, if_ack_o, d_ack_o, err_o, m_we_o, m_be_o}, 64'h0);
    check("midrst_bus", {m_addr_o, m_wdata_o}, 64'h0);
    tick();
    #2 rst = 1'b0;
    mem_delay = 0;
    done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_ack_o) done = 1'b1;
    end
    check("no_dack_after_rst", done, 1'b0);
    if_req_i = 1'b1; if_addr_i = 32'h44; mem_fix_en = 1'b1; mem_fix = 32'h1234_5678;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (if_ack_o) begin
        done = 1'b1;
        check("post_rst_fetch", if_rdata_o, 32'h1234_5678);
      end
    end
    check("post_rst_ack", done, 1'b1);
    tick();
    if_req_i = 1'b0;
    mem_fix_en = 1'b0;

    // Randomized traffic with spurious memory acks
    spur_en = 1'b1;
    if_rel = 1'b0; d_rel = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      mem_delay = $urandom_range(3);
      if (if_ack_o) if_rel = 1'b1;
      else if (!if_req_i || if_rel) begin
        if_rel = 1'b0;
        if_req_i = ($urandom_range(2) != 0);
        if_addr_i = $urandom;
      end
      if (d_ack_o) d_rel = 1'b1;
      else if (!d_req_i || d_rel) begin
        d_rel = 1'b0;
        d_req_i = ($urandom_range(2) != 0);
        d_we_i = 1'($urandom);
        d_be_i = 4'($urandom);
        d_addr_i = $urandom;
        d_wdata_i = $urandom;
      end
    end
    spur_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
